// File: rtl/lsu.sv
// Load/store unit: accepts execute results, performs at most one aligned doubleword memory
// transaction per instruction and hands the write-back value downstream.
module lsu #(
    parameter int unsigned CPU_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [CPU_WIDTH-1:0] i_exu_res,
    input  logic [CPU_WIDTH-1:0] i_rs2,
    input  logic [3:0]           i_lsu_opt,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    output logic                 o_mem_req_valid,
    input  logic                 i_mem_req_ready,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]           o_mem_wmask,
    input  logic                 i_mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata,
    output logic [CPU_WIDTH-1:0] o_lsu_res,
    output logic                 o_misalign,
    output logic                 o_post_valid,
    input  logic                 i_post_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
    logic [CPU_WIDTH-1:0] res_q, res_d;
    logic [7:0]           wmask_q, wmask_d;
    logic                 wen_q, wen_d;
    logic                 mis_q, mis_d;
    logic [3:0]           opt_q, opt_d;

    logic                 accept;
    logic                 is_load;
    logic                 is_store;
    logic                 misaligned;
    logic [1:0]           size;
    logic [2:0]           a;
    logic [7:0]           store_mask;
    logic [CPU_WIDTH-1:0] rshift;
    logic [CPU_WIDTH-1:0] load_val;

    // A finishing instruction frees the stage in the same cycle it is consumed downstream.
    assign o_pre_ready = (state_q == StIdle) || ((state_q == StDone) && i_post_ready);
    assign accept      = i_pre_valid && o_pre_ready;
    assign a           = i_exu_res[2:0];

    always_comb begin
        is_load  = (i_lsu_opt >= 4'd1) && (i_lsu_opt <= 4'd7);
        is_store = (i_lsu_opt >= 4'd8) && (i_lsu_opt <= 4'd11);
        case (i_lsu_opt)
            4'd2, 4'd6, 4'd9:  size = 2'd1;
            4'd3, 4'd7, 4'd10: size = 2'd2;
            4'd4, 4'd11:       size = 2'd3;
            default:           size = 2'd0;
        endcase
        case (size)
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a[1:0];
            2'd3:    misaligned = |a;
            default: misaligned = 1'b0;
        endcase
        case (size)
            2'd0:    store_mask = 8'h01 << a;
            2'd1:    store_mask = 8'h03 << a;
            2'd2:    store_mask = 8'h0F << a;
            default: store_mask = 8'hFF;
        endcase
    end

    always_comb begin
        rshift = i_mem_rdata >> {addr_q[2:0], 3'b000};
        case (opt_q)
            4'd1:    load_val = {{(CPU_WIDTH-8){rshift[7]}}, rshift[7:0]};
            4'd2:    load_val = {{(CPU_WIDTH-16){rshift[15]}}, rshift[15:0]};
            4'd3:    load_val = {{(CPU_WIDTH-32){rshift[31]}}, rshift[31:0]};
            4'd4:    load_val = rshift;
            4'd5:    load_val = {{(CPU_WIDTH-8){1'b0}}, rshift[7:0]};
            4'd6:    load_val = {{(CPU_WIDTH-16){1'b0}}, rshift[15:0]};
            4'd7:    load_val = {{(CPU_WIDTH-32){1'b0}}, rshift[31:0]};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wen_d   = wen_q;
        res_d   = res_q;
        mis_d   = mis_q;
        opt_d   = opt_q;
        case (state_q)
            StReq:   if (i_mem_req_ready) state_d = StWait;
            StWait: begin
                if (i_mem_rsp_valid) begin
                    state_d = StDone;
                    res_d   = load_val;
                    mis_d   = 1'b0;
                end
            end
            StDone:  if (i_post_ready) state_d = StIdle;
            default: ;
        endcase
        if (accept) begin
            opt_d = i_lsu_opt;
            if (!is_load && !is_store) begin
                state_d = StDone;
                res_d   = i_exu_res;
                mis_d   = 1'b0;
            end else if (misaligned) begin
                state_d = StDone;
                res_d   = '0;
                mis_d   = 1'b1;
            end else begin
                state_d = StReq;
                addr_d  = i_exu_res;
                wen_d   = is_store;
                wdata_d = is_store ? (i_rs2 << {a, 3'b000}) : '0;
                wmask_d = is_store ? store_mask : 8'h00;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            res_q   <= '0;
            mis_q   <= 1'b0;
            opt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
            res_q   <= res_d;
            mis_q   <= mis_d;
            opt_q   <= opt_d;
        end
    end

    assign o_mem_req_valid = (state_q == StReq);
    assign o_post_valid    = (state_q == StDone);
    assign o_mem_addr      = {addr_q[CPU_WIDTH-1:3], 3'b000};
    assign o_mem_wen       = wen_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wmask     = wmask_q;
    assign o_lsu_res       = res_q;
    assign o_misalign      = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, randomized ops against a byte-level reference model,
// and hand sequences for back-to-back issue and reset during an outstanding access.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] exu_res = '0;
    logic [63:0] rs2 = '0;
    logic [3:0]  lsu_opt = '0;
    logic        pre_valid = 1'b0;
    logic        pre_ready;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic [63:0] lsu_res;
    logic        misalign;
    logic        post_valid;
    logic        post_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu #(.CPU_WIDTH(64)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_exu_res       (exu_res),
        .i_rs2           (rs2),
        .i_lsu_opt       (lsu_opt),
        .i_pre_valid     (pre_valid),
        .o_pre_ready     (pre_ready),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wen       (mem_wen),
        .o_mem_wdata     (mem_wdata),
        .o_mem_wmask     (mem_wmask),
        .i_mem_rsp_valid (rsp_valid),
        .i_mem_rdata     (mem_rdata),
        .o_lsu_res       (lsu_res),
        .o_misalign      (misalign),
        .o_post_valid    (post_valid),
        .i_post_ready    (post_ready)
    );

    typedef struct {
        logic [3:0]  opt;
        logic [63:0] exu;
        logic [63:0] rs2;
        logic [63:0] rdata;
        int          rd;   // cycles of request backpressure
        int          sd;   // cycles before the response
        int          pd;   // cycles of write-back backpressure
        logic [63:0] exp_res;
        logic        exp_mis;
        logic        exp_mem;
        logic        exp_wen;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: operates on byte counts and byte offsets, not on the RTL's decode.
    function automatic vec_t model(input logic [3:0] opt, input logic [63:0] exu,
                                   input logic [63:0] d, input logic [63:0] rdata,
                                   input int rd, input int sd, input int pd);
        vec_t v;
        int nbytes = 0;
        bit sgn = 0, ld = 0, st = 0;
        int off;
        logic [63:0] mask, val;
        v = '{opt, exu, d, rdata, rd, sd, pd, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0};
        case (opt)
            4'd1: begin ld = 1; nbytes = 1; sgn = 1; end
            4'd2: begin ld = 1; nbytes = 2; sgn = 1; end
            4'd3: begin ld = 1; nbytes = 4; sgn = 1; end
            4'd4: begin ld = 1; nbytes = 8; end
            4'd5: begin ld = 1; nbytes = 1; end
            4'd6: begin ld = 1; nbytes = 2; end
            4'd7: begin ld = 1; nbytes = 4; end
            4'd8: begin st = 1; nbytes = 1; end
            4'd9: begin st = 1; nbytes = 2; end
            4'd10: begin st = 1; nbytes = 4; end
            4'd11: begin st = 1; nbytes = 8; end
            default: ;
        endcase
        if (!ld && !st) begin
            v.exp_res = exu;
            return v;
        end
        if ((exu % 64'(nbytes)) != 0) begin
            v.exp_mis = 1'b1;
            return v;
        end
        off = int'(exu % 64'd8);
        v.exp_mem  = 1'b1;
        v.exp_addr = exu - (exu % 64'd8);
        if (st) begin
            v.exp_wen   = 1'b1;
            v.exp_wmask = 8'(((1 << nbytes) - 1) << off);
            v.exp_wdata = d << (8 * off);
        end else begin
            val = rdata >> (8 * off);
            if (nbytes < 8) begin
                mask = (64'd1 << (8 * nbytes)) - 64'd1;
                val  = val & mask;
                if (sgn && val[8*nbytes-1]) val = val | ~mask;
            end
            v.exp_res = val;
        end
        return v;
    endfunction

    // Drives one instruction from IDLE through write-back and checks every observable step.
    task automatic run_vec(input vec_t v, input string tag);
        int  cyc = 0;
        int  req_cnt = 0;
        int  wait_cnt = 0;
        bit  done = 0;
        bit  got_req = 0;
        bit  in_wait = 0;
        @(negedge clk);
        pre_valid = 1'b1; lsu_opt = v.opt; exu_res = v.exu; rs2 = v.rs2; mem_rdata = v.rdata;
        post_ready = 1'b0; mem_req_ready = 1'b0; rsp_valid = 1'b0;
        #1 chk({tag, "_pre_ready_idle"}, pre_ready, 1'b1);
        @(posedge clk);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            pre_valid = 1'b0;
            exu_res = {$urandom, $urandom};
            rs2 = {$urandom, $urandom};
            lsu_opt = 4'($urandom_range(0, 15));
            mem_req_ready = 1'b0;
            rsp_valid = 1'b0;
            if (post_valid) begin
                chk({tag, "_res"}, lsu_res, v.exp_res);
                chk({tag, "_misalign"}, misalign, v.exp_mis);
                chk({tag, "_mem_used"}, got_req, v.exp_mem);
                chk({tag, "_latency"}, cyc, v.exp_mem ? 3 + v.rd + v.sd : 1);
                for (int k = 0; k < v.pd; k++) begin
                    pre_valid = 1'b1;
                    #1 chk({tag, "_pre_ready_held"}, pre_ready, 1'b0);
                    @(negedge clk);
                    chk({tag, "_post_valid_held"}, post_valid, 1'b1);
                    chk({tag, "_res_held"}, lsu_res, v.exp_res);
                end
                pre_valid = 1'b0;
                post_ready = 1'b1;
                #1 chk({tag, "_pre_ready_done"}, pre_ready, 1'b1);
                @(negedge clk);
                post_ready = 1'b0;
                #1 chk({tag, "_post_valid_drop"}, post_valid, 1'b0);
                done = 1;
            end else if (mem_req_valid) begin
                got_req = 1;
                req_cnt++;
                chk({tag, "_addr"}, mem_addr, v.exp_addr);
                chk({tag, "_wen"}, mem_wen, v.exp_wen);
                chk({tag, "_wdata"}, mem_wdata, v.exp_wdata);
                chk({tag, "_wmask"}, mem_wmask, v.exp_wmask);
                if (req_cnt > v.rd) begin
                    mem_req_ready = 1'b1;
                    in_wait = 1;
                end else begin
                    rsp_valid = 1'b1;  // stray response before the handshake must be ignored
                end
            end else if (in_wait) begin
                wait_cnt++;
                if (wait_cnt == v.sd + 1) rsp_valid = 1'b1;
            end
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout: got no post_valid expected one within 60 cycles", tag);
        end
    endtask

    localparam int NDIR = 13;
    vec_t dir[NDIR];
    vec_t rv;
    logic [63:0] rexu;

    initial begin
        dir[0]  = '{4'd0, 64'h1234, 64'h0, 64'h0, 0, 0, 0,
                    64'h1234, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00};
        dir[1]  = '{4'd1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0,
                    64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1, 1'b0, 64'h8000_0000, 64'h0, 8'h00};
        dir[2]  = '{4'd5, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 1, 0,
                    64'h80, 1'b0, 1'b1, 1'b0, 64'h8000_0000, 64'h0, 8'h00};
        dir[3]  = '{4'd9, 64'h8000_0006, 64'hABCD, 64'h0, 0, 0, 0,
                    64'h0, 1'b0, 1'b1, 1'b1, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0};
        dir[4]  = '{4'd3, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 0,
                    64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00};
        dir[5]  = '{4'd4, 64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 1, 2,
                    64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b0, 64'h8000_0008, 64'h0, 8'h00};
        dir[6]  = '{4'd11, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, 0, 0,
                    64'h0, 1'b0, 1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF};
        dir[7]  = '{4'd2, 64'h1002, 64'h0, 64'h0000_0000_8001_0000, 0, 2, 0,
                    64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h0, 8'h00};
        dir[8]  = '{4'd7, 64'h4, 64'h0, 64'hF000_0000_0000_0000, 0, 0, 1,
                    64'h0000_0000_F000_0000, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 8'h00};
        dir[9]  = '{4'd3, 64'h4, 64'h0, 64'hF000_0000_0000_0000, 0, 0, 0,
                    64'hFFFF_FFFF_F000_0000, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 8'h00};
        dir[10] = '{4'd13, 64'h5555_AAAA, 64'h0, 64'h0, 0, 0, 0,
                    64'h5555_AAAA, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00};
        dir[11] = '{4'd10, 64'h4, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 0,
                    64'h0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h5566_7788_0000_0000, 8'hF0};
        dir[12] = '{4'd9, 64'h1, 64'hFFFF, 64'h0, 0, 0, 1,
                    64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00};

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_pre_ready", pre_ready, 1'b1);
        chk("rst_post_valid", post_valid, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_wen", mem_wen, 1'b0);
        chk("rst_addr", mem_addr, 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_wmask", mem_wmask, 8'h00);
        chk("rst_res", lsu_res, 64'h0);
        chk("rst_misalign", misalign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NDIR; i++) run_vec(dir[i], $sformatf("dir%0d", i));

        // Three back-to-back NONE instructions at full rate
        @(negedge clk);
        post_ready = 1'b1;
        pre_valid  = 1'b1;
        lsu_opt    = 4'd0;
        exu_res    = 64'hA1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_valid%0d", k), post_valid, 1'b1);
            chk($sformatf("b2b_res%0d", k), lsu_res, 64'hA1 + 64'(k));
            exu_res = 64'hA1 + 64'(k + 1);
            if (k == 2) pre_valid = 1'b0;
            #1 chk($sformatf("b2b_pre_ready%0d", k), pre_ready, 1'b1);
            @(negedge clk);
        end
        chk("b2b_end_valid", post_valid, 1'b0);
        post_ready = 1'b0;

        // Reset during WAIT, then a stray response after release
        @(negedge clk);
        pre_valid = 1'b1; lsu_opt = 4'd1; exu_res = 64'h8000_0003;
        mem_req_ready = 1'b1;
        @(negedge clk);
        pre_valid = 1'b0;
        chk("rstw_req_valid", mem_req_valid, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstw_in_wait", mem_req_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstw_post_valid", post_valid, 1'b0);
        chk("rstw_pre_ready", pre_ready, 1'b1);
        chk("rstw_addr", mem_addr, 64'h0);
        chk("rstw_res", lsu_res, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_valid = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstw_no_post%0d", k), post_valid, 1'b0);
            chk($sformatf("rstw_no_req%0d", k), mem_req_valid, 1'b0);
            chk($sformatf("rstw_res_zero%0d", k), lsu_res, 64'h0);
            @(negedge clk);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rexu = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rexu[1:0] = 2'b00;
            rv = model(4'($urandom_range(0, 15)), rexu, {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2));
            run_vec(rv, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
